// File: rtl/req_grant_if.sv
// rtl/req_grant_if.sv - REQ/GNT handshake and status bundle for req_grant_ctrl
interface req_grant_if #(
    parameter int PEND_MAX = 4,
    parameter int CNT_W    = 32
);
    localparam int PW = $clog2(PEND_MAX + 1);

    logic             req;
    logic             cancel;
    logic             gnt;
    logic [CNT_W-1:0] req_num;
    logic [CNT_W-1:0] gnt_num;
    logic [PW-1:0]    pending;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf;
    logic             busy;

    modport master (
        output req, cancel,
        input  gnt, req_num, gnt_num, pending, drop_cnt, ovf, busy
    );

    modport slave (
        input  req, cancel,
        output gnt, req_num, gnt_num, pending, drop_cnt, ovf, busy
    );
endinterface

// File: rtl/req_grant_ctrl.sv
// rtl/req_grant_ctrl.sv - grant-side responder: queues REQ rises, answers each with a delayed GNT pulse
module req_grant_ctrl #(
    parameter int GNT_DLY  = 3,
    parameter int PEND_MAX = 4,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    req_grant_if.slave   bus
);
    localparam int              PW      = $clog2(PEND_MAX + 1);
    localparam logic [PW-1:0]   PEND_LIM = PW'(PEND_MAX);
    localparam logic [3:0]      DLY_LIM  = 4'(GNT_DLY);

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

    state_t     state;
    logic [3:0] dly_cnt;
    logic       req_q;
    logic       rise;
    logic       retire;
    logic       accept;

    assign rise     = bus.req & ~req_q;
    assign retire   = (state == WAIT) && (dly_cnt == DLY_LIM);
    assign accept   = rise && ((bus.pending < PEND_LIM) || retire);
    assign bus.busy = (state != IDLE) || (bus.pending != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dly_cnt      <= '0;
            // Track req through reset so a level held across reset is not seen as a new rise.
            req_q        <= bus.req;
            bus.gnt      <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.pending  <= '0;
            bus.req_num  <= '0;
            bus.gnt_num  <= '0;
            bus.drop_cnt <= '0;
        end else begin
            req_q <= bus.req;
            if (bus.cancel) begin
                state        <= IDLE;
                dly_cnt      <= '0;
                bus.gnt      <= 1'b0;
                bus.pending  <= '0;
                bus.drop_cnt <= bus.drop_cnt + CNT_W'(bus.pending) + CNT_W'(rise);
            end else begin
                case (state)
                    IDLE: begin
                        bus.gnt <= 1'b0;
                        if (bus.pending != '0) begin
                            state   <= WAIT;
                            dly_cnt <= 4'd1;
                        end
                    end
                    WAIT: begin
                        if (retire) begin
                            state       <= GRANT;
                            bus.gnt     <= 1'b1;
                            bus.gnt_num <= bus.gnt_num + 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt + 4'd1;
                        end
                    end
                    GRANT: begin
                        state   <= IDLE;
                        bus.gnt <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        bus.gnt <= 1'b0;
                    end
                endcase

                // A grant retiring on the accept edge frees the slot it needs.
                case ({accept, retire})
                    2'b10:   bus.pending <= bus.pending + 1'b1;
                    2'b01:   bus.pending <= bus.pending - 1'b1;
                    default: bus.pending <= bus.pending;
                endcase

                if (accept) begin
                    bus.req_num <= bus.req_num + 1'b1;
                end else if (rise) begin
                    bus.drop_cnt <= bus.drop_cnt + 1'b1;
                    bus.ovf      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_req_grant_ctrl.sv
// tb/tb_req_grant_ctrl.sv - randomized bench for req_grant_ctrl against a timeline reference model
module tb_req_grant_ctrl;
    localparam int GNT_DLY  = 3;
    localparam int PEND_MAX = 4;
    localparam int CNT_W    = 32;

    logic clk;
    logic reset;

    req_grant_if #(.PEND_MAX(PEND_MAX), .CNT_W(CNT_W)) bus ();

    req_grant_ctrl #(.GNT_DLY(GNT_DLY), .PEND_MAX(PEND_MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: grants are scheduled on an edge timeline, not a state machine.
    int          t;
    int          grant_at;
    int          free_at;
    int          m_pend;
    logic [31:0] m_req_num;
    logic [31:0] m_gnt_num;
    logic [31:0] m_drop;
    logic        m_ovf;
    logic        m_gnt;
    logic        m_req_q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic rs);
        logic rise;
        logic retire;
        logic start;
        if (rs) begin
            grant_at  = -1;
            free_at   = 0;
            m_pend    = 0;
            m_req_num = '0;
            m_gnt_num = '0;
            m_drop    = '0;
            m_ovf     = 1'b0;
            m_gnt     = 1'b0;
            m_req_q   = r;
        end else begin
            rise    = r & ~m_req_q;
            m_req_q = r;
            retire  = (grant_at == t);
            if (c) begin
                m_drop   = m_drop + 32'(m_pend) + 32'(rise);
                m_pend   = 0;
                grant_at = -1;
                m_gnt    = 1'b0;
                free_at  = t + 1;
            end else begin
                start = (grant_at < 0) && (t >= free_at) && (m_pend > 0);
                m_gnt = retire;
                if (retire) begin
                    m_gnt_num = m_gnt_num + 1;
                    grant_at  = -1;
                    free_at   = t + 2;
                end
                if (start) grant_at = t + GNT_DLY;
                if (rise) begin
                    if (m_pend < PEND_MAX || retire) begin
                        m_req_num = m_req_num + 1;
                        m_pend    = m_pend + 1;
                    end else begin
                        m_drop = m_drop + 1;
                        m_ovf  = 1'b1;
                    end
                end
                if (retire) m_pend = m_pend - 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rs);
        @(negedge clk);
        bus.req    = r;
        bus.cancel = c;
        reset      = rs;
        @(posedge clk);
        model_edge(r, c, rs);
        t++;
        #1;
        check_val("gnt",      32'(bus.gnt),      32'(m_gnt));
        check_val("req_num",  bus.req_num,       m_req_num);
        check_val("gnt_num",  bus.gnt_num,       m_gnt_num);
        check_val("pending",  32'(bus.pending),  32'(m_pend));
        check_val("drop_cnt", bus.drop_cnt,      m_drop);
        check_val("ovf",      32'(bus.ovf),      32'(m_ovf));
        check_val("busy",     32'(bus.busy),
                  32'((grant_at >= 0) || m_gnt || (m_pend != 0)));
    endtask

    task automatic random_phase(input int cycles, input int p_high, input int p_cancel, input int p_reset);
        logic r;
        logic c;
        logic rs;
        for (int i = 0; i < cycles; i++) begin
            r  = ($urandom_range(0, 99) < p_high);
            c  = ($urandom_range(0, 99) < p_cancel);
            rs = ($urandom_range(0, 999) < p_reset);
            step(r, c, rs);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        t          = 0;
        bus.req    = 1'b0;
        bus.cancel = 1'b0;
        reset      = 1'b1;
        model_edge(1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Single request and its latency.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        // Four pulses with rises two cycles apart.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0);

        // Six rises in twelve cycles to force overflow.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        // Cancel while requests are queued.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

        // Reset mid-flight with req held high across it.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GNT_DLY + 1; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        random_phase(400, 20, 0, 0);
        random_phase(400, 50, 0, 0);
        random_phase(600, 50, 4, 0);
        random_phase(600, 45, 3, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
